// File: rtl/vdp_euler_core.sv
// Fixed-point forward-Euler Van der Pol solver; one Euler step takes six
// cycles, sharing two multipliers and one add/sub path across the schedule.
module vdp_euler_core #(
  parameter int W     = 32,
  parameter int FRAC  = 16,
  parameter int CW    = 16,
  parameter int DECIM = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  input  logic signed [W-1:0] ext_mu,
  input  logic signed [W-1:0] ext_dt,
  input  logic signed [W-1:0] ext_a,
  input  logic signed [W-1:0] ext_x0,
  input  logic signed [W-1:0] ext_y0,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic                sat_flag,
  output logic                sample_valid,
  output logic signed [W-1:0] x_out,
  output logic signed [W-1:0] y_out,
  output logic signed [W-1:0] t_out,
  output logic [CW-1:0]       step_count
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_S1   = 3'd1;
  localparam logic [2:0] ST_S2   = 3'd2;
  localparam logic [2:0] ST_S3   = 3'd3;
  localparam logic [2:0] ST_S4   = 3'd4;
  localparam logic [2:0] ST_S5   = 3'd5;
  localparam logic [2:0] ST_S6   = 3'd6;

  localparam int DW = (DECIM > 1) ? $clog2(DECIM) : 1;

  localparam logic signed [W-1:0] ONE   = W'(1) << FRAC;
  localparam logic signed [W-1:0] MAX_W = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] MIN_W = {1'b1, {(W-1){1'b0}}};
  localparam logic [CW-1:0]       MAX_STEPS = {CW{1'b1}};

  // Result format {saturated, value}: product of Q(FRAC) operands rescaled by
  // an arithmetic shift, clamped to the W-bit range.
  function automatic logic [W:0] f_mul(input logic signed [W-1:0] p,
                                       input logic signed [W-1:0] q);
    logic signed [2*W-1:0] pe;
    logic signed [2*W-1:0] qe;
    logic signed [2*W-1:0] sh;
    pe = {{W{p[W-1]}}, p};
    qe = {{W{q[W-1]}}, q};
    sh = (pe * qe) >>> FRAC;
    if ((&sh[2*W-1:W-1]) || !(|sh[2*W-1:W-1]))
      return {1'b0, sh[W-1:0]};
    else if (sh[2*W-1])
      return {1'b1, MIN_W};
    else
      return {1'b1, MAX_W};
  endfunction

  function automatic logic [W:0] f_addsub(input logic signed [W-1:0] p,
                                          input logic signed [W-1:0] q,
                                          input logic                sub);
    logic [W:0] s;
    s = sub ? ({p[W-1], p} - {q[W-1], q}) : ({p[W-1], p} + {q[W-1], q});
    if (s[W] == s[W-1])
      return {1'b0, s[W-1:0]};
    else if (s[W])
      return {1'b1, MIN_W};
    else
      return {1'b1, MAX_W};
  endfunction

  logic [2:0]          state;
  logic [DW-1:0]       dec_cnt;
  logic signed [W-1:0] mu, dt, a, x, y, t;
  logic signed [W-1:0] xx, dx, tn, ra, xdt, rb, rc, rd;

  logic signed [W-1:0] m0_p, m0_q, m1_p, m1_q, as_p, as_q;
  logic                as_sub;
  logic [W:0]          m0, m1, as_r, cx, cy1, cy2;
  logic [CW-1:0]       step_new;
  logic                fin, emit;

  // Operand steering for the shared multipliers and adder across the schedule.
  always_comb begin
    m0_p   = x;
    m0_q   = x;
    m1_p   = y;
    m1_q   = dt;
    as_p   = t;
    as_q   = dt;
    as_sub = 1'b0;
    case (state)
      ST_S2: begin
        m0_q   = dt;
        as_p   = ONE;
        as_q   = xx;
        as_sub = 1'b1;
      end
      ST_S3: begin
        m0_p = mu;
        m0_q = ra;
      end
      ST_S4: begin
        m0_p = rb;
        m0_q = y;
      end
      ST_S5: begin
        m0_p = rc;
        m0_q = dt;
      end
      default: ;
    endcase
    m0       = f_mul(m0_p, m0_q);
    m1       = f_mul(m1_p, m1_q);
    as_r     = f_addsub(as_p, as_q, as_sub);
    cx       = f_addsub(x, dx, 1'b0);
    cy1      = f_addsub(y, rd, 1'b0);
    cy2      = f_addsub(cy1[W-1:0], xdt, 1'b1);
    step_new = step_count + 1'b1;
    fin      = (tn >= a) || (step_new == MAX_STEPS);
    emit     = (dec_cnt == DW'(DECIM - 1)) || fin;
  end

  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= ST_IDLE;
      dec_cnt      <= '0;
      mu           <= '0;
      dt           <= '0;
      a            <= '0;
      x            <= '0;
      y            <= '0;
      t            <= '0;
      xx           <= '0;
      dx           <= '0;
      tn           <= '0;
      ra           <= '0;
      xdt          <= '0;
      rb           <= '0;
      rc           <= '0;
      rd           <= '0;
      done         <= 1'b0;
      err          <= 1'b0;
      sat_flag     <= 1'b0;
      sample_valid <= 1'b0;
      x_out        <= '0;
      y_out        <= '0;
      t_out        <= '0;
      step_count   <= '0;
    end else begin
      done         <= 1'b0;
      sample_valid <= 1'b0;
      if (state == ST_IDLE) begin
        if (start) begin
          mu         <= ext_mu;
          dt         <= ext_dt;
          a          <= ext_a;
          x          <= ext_x0;
          y          <= ext_y0;
          t          <= '0;
          step_count <= '0;
          dec_cnt    <= '0;
          err        <= 1'b0;
          sat_flag   <= 1'b0;
          if (ext_dt[W-1] || (ext_dt == '0)) begin
            err  <= 1'b1;
            done <= 1'b1;
          end else if (ext_a[W-1] || (ext_a == '0)) begin
            done <= 1'b1;
          end else begin
            state <= ST_S1;
          end
        end
      end else if (abort) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_S1: begin
            xx       <= m0[W-1:0];
            dx       <= m1[W-1:0];
            tn       <= as_r[W-1:0];
            sat_flag <= sat_flag | m0[W] | m1[W] | as_r[W];
            state    <= ST_S2;
          end
          ST_S2: begin
            ra       <= as_r[W-1:0];
            xdt      <= m0[W-1:0];
            sat_flag <= sat_flag | m0[W] | as_r[W];
            state    <= ST_S3;
          end
          ST_S3: begin
            rb       <= m0[W-1:0];
            sat_flag <= sat_flag | m0[W];
            state    <= ST_S4;
          end
          ST_S4: begin
            rc       <= m0[W-1:0];
            sat_flag <= sat_flag | m0[W];
            state    <= ST_S5;
          end
          ST_S5: begin
            rd       <= m0[W-1:0];
            sat_flag <= sat_flag | m0[W];
            state    <= ST_S6;
          end
          ST_S6: begin
            x          <= cx[W-1:0];
            y          <= cy2[W-1:0];
            t          <= tn;
            step_count <= step_new;
            sat_flag   <= sat_flag | cx[W] | cy1[W] | cy2[W];
            dec_cnt    <= emit ? '0 : dec_cnt + 1'b1;
            if (emit) begin
              x_out        <= cx[W-1:0];
              y_out        <= cy2[W-1:0];
              t_out        <= tn;
              sample_valid <= 1'b1;
            end
            if (fin) begin
              done  <= 1'b1;
              state <= ST_IDLE;
            end else begin
              state <= ST_S1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vdp_euler_core.sv
// Directed bench for vdp_euler_core: a vector table of whole runs plus
// hand-written abort, decimation/step-limit and mid-run reset sequences.
module tb_vdp_euler_core;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, abort;
  logic [31:0] mu, dt, a, x0, y0;
  logic        busy, done, err, sat_flag, sample_valid;
  logic [31:0] x_out, y_out, t_out;
  logic [15:0] step_count;

  logic        start4;
  logic        busy4, done4, err4, sat4, sv4;
  logic [31:0] x4, y4, t4;
  logic [2:0]  sc4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vdp_euler_core dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .ext_mu(mu), .ext_dt(dt), .ext_a(a), .ext_x0(x0), .ext_y0(y0),
    .busy(busy), .done(done), .err(err), .sat_flag(sat_flag),
    .sample_valid(sample_valid), .x_out(x_out), .y_out(y_out), .t_out(t_out),
    .step_count(step_count)
  );

  vdp_euler_core #(.W(32), .FRAC(16), .CW(3), .DECIM(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .abort(1'b0),
    .ext_mu(32'h0), .ext_dt(32'h1000), .ext_a(32'h7FFF_FFFF), .ext_x0(32'h0), .ext_y0(32'h0),
    .busy(busy4), .done(done4), .err(err4), .sat_flag(sat4),
    .sample_valid(sv4), .x_out(x4), .y_out(y4), .t_out(t4),
    .step_count(sc4)
  );

  typedef struct {
    logic [31:0] mu, dt, a, x0, y0;
    logic [31:0] ex, ey, et;
    int          steps;
    int          samples;
    bit          eerr;
    bit          esat;
  } vec_t;

  vec_t vecs[9];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input vec_t v, output int done_cyc, output int n_samp,
                                output bit busy_seen, output logic [31:0] lx,
                                output logic [31:0] ly, output logic [31:0] lt);
    @(negedge clk);
    mu = v.mu; dt = v.dt; a = v.a; x0 = v.x0; y0 = v.y0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    done_cyc = -1; n_samp = 0; busy_seen = 1'b0;
    lx = '0; ly = '0; lt = '0;
    for (int c = 1; c <= 200; c++) begin
      if (busy) busy_seen = 1'b1;
      if (sample_valid) begin
        n_samp++;
        lx = x_out; ly = y_out; lt = t_out;
      end
      if (done) begin
        done_cyc = c;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          done_cyc, n_samp, exp_lat, n_dn;
    bit          busy_seen;
    logic [31:0] lx, ly, lt;
    int          s4_cnt, s4_first_cyc, s4_done_cyc;
    logic [31:0] s4_first_t, s4_first_sc, s4_last_t, s4_last_sc;

    //             mu           dt           a            x0           y0           ex           ey           et      steps smp err sat
    vecs[0] = '{32'h0,       32'h1000,    32'h2000,    32'h10000,   32'h0,       32'hFF00,    32'hFFFF_E000, 32'h2000, 2, 2, 1'b0, 1'b0};
    vecs[1] = '{32'h0,       32'h1000,    32'h1000,    32'h10000,   32'h0,       32'h10000,   32'hFFFF_F000, 32'h1000, 1, 1, 1'b0, 1'b0};
    vecs[2] = '{32'h0,       32'h0,       32'h2000,    32'h10000,   32'h0,       32'h0,       32'h0,         32'h0,    0, 0, 1'b1, 1'b0};
    vecs[3] = '{32'h0,       32'h1000,    32'h0,       32'h10000,   32'h0,       32'h0,       32'h0,         32'h0,    0, 0, 1'b0, 1'b0};
    vecs[4] = '{32'h0,       32'h10000,   32'h10000,   32'h7FFF_0000, 32'h7FFF_0000, 32'h7FFF_FFFF, 32'h0,   32'h10000, 1, 1, 1'b0, 1'b1};
    vecs[5] = '{32'h10000,   32'h1000,    32'h1000,    32'h0,       32'h10000,   32'h1000,    32'h11000,     32'h1000, 1, 1, 1'b0, 1'b0};
    vecs[6] = '{32'h20000,   32'h4000,    32'h4000,    32'h8000,    32'h20000,   32'h10000,   32'h2A000,     32'h4000, 1, 1, 1'b0, 1'b0};
    vecs[7] = '{32'h0,       32'h4000,    32'h4000,    32'hFFFF_8000, 32'h0,     32'hFFFF_8000, 32'h2000,    32'h4000, 1, 1, 1'b0, 1'b0};
    vecs[8] = '{32'h0,       32'hFFFF_F000, 32'h4000,  32'h10000,   32'h0,       32'h0,       32'h0,         32'h0,    0, 0, 1'b1, 1'b0};

    reset = 1'b0; start = 1'b0; abort = 1'b0; start4 = 1'b0;
    mu = '0; dt = '0; a = '0; x0 = '0; y0 = '0;
    repeat (3) @(negedge clk);
    check_output("reset_outputs", {busy, done, err, sat_flag, sample_valid}, 32'h0);
    check_output("reset_xyt", x_out | y_out | t_out | {16'h0, step_count}, 32'h0);
    check_output("reset_dut4", {busy4, done4, err4, sat4, sv4, sc4}, 32'h0);
    reset = 1'b1;
    @(negedge clk);
    $display("[TB] reset released, running vector table");

    for (int i = 0; i < 9; i++) begin
      apply_stimulus(vecs[i], done_cyc, n_samp, busy_seen, lx, ly, lt);
      exp_lat = (vecs[i].steps == 0) ? 1 : 6 * vecs[i].steps + 1;
      check_output($sformatf("v%0d_done_latency", i), done_cyc, exp_lat);
      check_output($sformatf("v%0d_samples", i), n_samp, vecs[i].samples);
      check_output($sformatf("v%0d_busy_seen", i), {31'h0, busy_seen}, {31'h0, vecs[i].steps > 0});
      check_output($sformatf("v%0d_err", i), {31'h0, err}, {31'h0, vecs[i].eerr});
      check_output($sformatf("v%0d_sat", i), {31'h0, sat_flag}, {31'h0, vecs[i].esat});
      check_output($sformatf("v%0d_step_count", i), {16'h0, step_count}, vecs[i].steps);
      if (vecs[i].samples > 0) begin
        check_output($sformatf("v%0d_x", i), lx, vecs[i].ex);
        check_output($sformatf("v%0d_y", i), ly, vecs[i].ey);
        check_output($sformatf("v%0d_t", i), lt, vecs[i].et);
      end
      repeat (2) @(negedge clk);
    end

    // Abort during step 3, state S4 (cycle 16 after accept).
    $display("[TB] abort sequence");
    @(negedge clk);
    mu = 32'h0; dt = 32'h1000; a = 32'h100000; x0 = 32'h10000; y0 = 32'h0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_samp = 0; n_dn = 0;
    for (int c = 1; c < 16; c++) begin
      if (sample_valid) n_samp++;
      if (done) n_dn++;
      @(negedge clk);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_output("abort_busy_drop", {31'h0, busy}, 32'h0);
    check_output("abort_samples_before", n_samp, 2);
    for (int c = 0; c < 12; c++) begin
      if (sample_valid) n_samp++;
      if (done) n_dn++;
      @(negedge clk);
    end
    check_output("abort_no_done", n_dn, 0);
    check_output("abort_no_more_samples", n_samp, 2);
    check_output("abort_x_hold", x_out, 32'hFF00);
    check_output("abort_y_hold", y_out, 32'hFFFF_E000);
    check_output("abort_t_hold", t_out, 32'h2000);
    check_output("abort_step_count", {16'h0, step_count}, 32'd2);

    // Decimation by 4 with a 3-bit step counter; a mid-run start is ignored.
    $display("[TB] decimation / step-limit sequence");
    @(negedge clk);
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    s4_cnt = 0; s4_first_cyc = -1; s4_done_cyc = -1;
    s4_first_t = '0; s4_first_sc = '0; s4_last_t = '0; s4_last_sc = '0;
    for (int c = 1; c <= 80; c++) begin
      start4 = (c == 10);
      if (sv4) begin
        s4_cnt++;
        if (s4_cnt == 1) begin
          s4_first_cyc = c;
          s4_first_t = t4;
          s4_first_sc = {29'h0, sc4};
        end
        s4_last_t = t4;
        s4_last_sc = {29'h0, sc4};
      end
      if (done4) begin
        s4_done_cyc = c;
        break;
      end
      @(negedge clk);
    end
    start4 = 1'b0;
    check_output("decim_sample_count", s4_cnt, 2);
    check_output("decim_first_cycle", s4_first_cyc, 25);
    check_output("decim_first_t", s4_first_t, 32'h4000);
    check_output("decim_first_steps", s4_first_sc, 32'd4);
    check_output("decim_done_cycle", s4_done_cyc, 43);
    check_output("decim_last_t", s4_last_t, 32'h7000);
    check_output("decim_last_steps", s4_last_sc, 32'd7);

    // Reset asserted mid-run discards everything.
    $display("[TB] mid-run reset sequence");
    @(negedge clk);
    mu = 32'h0; dt = 32'h1000; a = 32'h100000; x0 = 32'h10000; y0 = 32'h0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check_output("rst_flags", {busy, done, err, sat_flag, sample_valid}, 32'h0);
    check_output("rst_x", x_out, 32'h0);
    check_output("rst_y", y_out, 32'h0);
    check_output("rst_t", t_out, 32'h0);
    check_output("rst_step_count", {16'h0, step_count}, 32'h0);
    n_dn = 0;
    for (int c = 0; c < 20; c++) begin
      if (done || sample_valid || busy) n_dn++;
      @(negedge clk);
    end
    check_output("rst_stays_idle", n_dn, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
